// File: rtl/mem_arb_pkg.sv
// Shared definitions for the unified memory-port arbiter: owner encoding and
// default burst / starvation limits.
package mem_arb_pkg;

    typedef enum logic {
        S_CORE = 1'b0,
        S_DMA  = 1'b1
    } arb_state_e;

    localparam int unsigned BURST_MAX_DEF  = 8;
    localparam int unsigned STARVE_LIM_DEF = 16;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between the RISC-V core (priority)
// and a DMA requester with bounded bursts and a starvation guarantee.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BURST_MAX  = BURST_MAX_DEF,
    parameter int unsigned STARVE_LIM = STARVE_LIM_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic              core_we,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic              dma_we,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned BW = $clog2(BURST_MAX + 1);
    localparam int unsigned WW = $clog2(STARVE_LIM + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_MAX - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(STARVE_LIM - 1);

    arb_state_e    state, state_nxt;
    logic [BW-1:0] beat_cnt, beat_nxt;
    logic [WW-1:0] wait_cnt, wait_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CORE;
            beat_cnt   <= '0;
            wait_cnt   <= '0;
            dma_rvalid <= 1'b0;
        end else begin
            state      <= state_nxt;
            beat_cnt   <= beat_nxt;
            wait_cnt   <= wait_nxt;
            dma_rvalid <= dma_gnt & ~dma_we;
        end
    end

    always_comb begin
        state_nxt  = state;
        beat_nxt   = beat_cnt;
        wait_nxt   = wait_cnt;
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_we     = core_we & core_req;
        core_stall = 1'b0;
        dma_gnt    = 1'b0;

        unique case (state)
            S_CORE: begin
                if (dma_req && (!core_req || wait_cnt == WAIT_LAST)) begin
                    state_nxt = S_DMA;
                    wait_nxt  = '0;
                end else if (dma_req && core_req) begin
                    // Cannot pass WAIT_LAST: reaching it forces the handover above.
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            S_DMA: begin
                mem_addr   = dma_addr;
                mem_wdata  = dma_wdata;
                mem_we     = dma_we & dma_req;
                dma_gnt    = dma_req;
                core_stall = core_req;
                if (!dma_req || (core_req && beat_cnt == BEAT_LAST)) begin
                    state_nxt = S_CORE;
                    beat_nxt  = '0;
                end else if (beat_cnt != BEAT_LAST) begin
                    beat_nxt = beat_cnt + 1'b1;
                end
            end
        endcase
    end

    assign core_rdata = mem_rdata;
    assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner
// sequences and constrained-random traffic against a cycle-level model.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BM = 8;
    localparam int unsigned SL = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] dma_addr = '0;
    logic [DW-1:0] dma_wdata = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic [DW-1:0] core_rdata, dma_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic          core_stall, dma_gnt, dma_rvalid, mem_we;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM), .STARVE_LIM(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_addr(core_addr), .core_we(core_we),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .dma_req(dma_req), .dma_addr(dma_addr), .dma_we(dma_we),
        .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
        .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference: who owns the port, how long DMA has waited, beats in burst.
    bit m_dma = 1'b0;
    bit m_rv = 1'b0;
    int m_waited = 0;
    int m_beats = 0;

    // Outputs sampled at the most recent negedge.
    logic          s_gnt, s_stall, s_rv, s_we;
    logic [AW-1:0] s_addr;

    task automatic check(string name, int idx, logic [131:0] got, logic [131:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, got, exp);
        end
    endtask

    function automatic logic [131:0] model_out();
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] w;
        if (m_dma) begin
            a = dma_addr; w = dma_wdata; we = dma_req & dma_we;
        end else begin
            a = core_addr; w = core_wdata; we = core_req & core_we;
        end
        return {m_dma & core_req, m_dma & dma_req, m_rv, we, a, w, mem_rdata, mem_rdata};
    endfunction

    task automatic model_update();
        bit gnt;
        gnt = m_dma && dma_req;
        if (reset) begin
            m_dma = 1'b0; m_rv = 1'b0; m_waited = 0; m_beats = 0;
        end else begin
            m_rv = gnt && !dma_we;
            if (!m_dma) begin
                if (dma_req && (!core_req || m_waited + 1 >= SL)) begin
                    m_dma = 1'b1; m_waited = 0;
                end else if (dma_req && core_req) begin
                    m_waited++;
                end
            end else begin
                if (!dma_req || (core_req && m_beats + 1 >= BM)) begin
                    m_dma = 1'b0; m_beats = 0;
                end else begin
                    m_beats++;
                end
            end
        end
    endtask

    int step_no = 0;
    task automatic step();
        mem_rdata = $urandom;
        @(negedge clk);
        s_gnt = dma_gnt; s_stall = core_stall; s_rv = dma_rvalid;
        s_we = mem_we; s_addr = mem_addr;
        if (chk_en)
            check("model", step_no,
                  {core_stall, dma_gnt, dma_rvalid, mem_we, mem_addr, mem_wdata, core_rdata, dma_rdata},
                  model_out());
        @(posedge clk);
        model_update();
        step_no++;
        #1;
    endtask

    task automatic idle(int n);
        reset = 1'b0; core_req = 1'b0; dma_req = 1'b0; core_we = 1'b0; dma_we = 1'b0;
        for (int i = 0; i < n; i++) step();
    endtask

    typedef struct packed {
        logic rst, creq, cwe, dreq, dwe;
        logic e_gnt, e_stall, e_we, e_rv, e_dma;
    } vec_t;

    vec_t vt [12];

    initial begin
        int bad, grants, waits, rv_ok, stalls;
        bit prev_gnt, exp_own;

        //               rst creq cwe dreq dwe | gnt stall we rv dma
        vt[0]  = 10'b0_1_1_0_0__0_0_1_0_0;
        vt[1]  = 10'b0_0_1_1_0__0_0_0_0_0;
        vt[2]  = 10'b0_0_0_1_0__1_0_0_0_1;
        vt[3]  = 10'b0_0_0_1_1__1_0_1_1_1;
        vt[4]  = 10'b0_1_0_1_0__1_1_0_0_1;
        vt[5]  = 10'b0_1_0_0_0__0_1_0_1_1;
        vt[6]  = 10'b0_1_0_1_0__0_0_0_0_0;
        vt[7]  = 10'b1_1_1_1_0__0_0_1_0_0;
        vt[8]  = 10'b0_0_0_1_1__0_0_0_0_0;
        vt[9]  = 10'b0_0_0_1_1__1_0_1_0_1;
        vt[10] = 10'b1_0_0_1_0__1_0_0_0_1;
        vt[11] = 10'b0_0_0_0_0__0_0_0_0_0;

        reset = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        check("reset_state", 0, {129'd0, s_stall, s_gnt, s_rv}, 132'd0);

        for (int i = 0; i < 12; i++) begin
            reset = vt[i].rst; core_req = vt[i].creq; core_we = vt[i].cwe;
            dma_req = vt[i].dreq; dma_we = vt[i].dwe;
            core_addr = 32'hC000_0000 + i; dma_addr = 32'hD000_0000 + i;
            core_wdata = $urandom; dma_wdata = $urandom;
            step();
            check("vec", i, {96'd0, s_gnt, s_stall, s_we, s_rv, s_addr},
                  {96'd0, vt[i].e_gnt, vt[i].e_stall, vt[i].e_we, vt[i].e_rv,
                   vt[i].e_dma ? dma_addr : core_addr});
        end
        idle(2);

        // Core alone owns the port for 50 cycles.
        bad = 0;
        for (int c = 0; c < 50; c++) begin
            core_req = 1'b1; core_we = 1'(c % 3 == 0); core_addr = $urandom;
            step();
            if (s_stall || s_addr !== core_addr || s_we !== core_we) bad++;
        end
        check("core_only", 0, 132'(bad), 132'd0);
        idle(2);

        // Four DMA reads with the core idle.
        grants = 0; waits = 0; rv_ok = 0; prev_gnt = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0;
        for (int c = 0; c < 12 && grants < 4; c++) begin
            dma_addr = 32'hA000_0000 + grants;
            step();
            if (prev_gnt && s_rv) rv_ok++;
            prev_gnt = s_gnt;
            if (s_gnt) grants++; else waits++;
        end
        dma_req = 1'b0;
        step();
        if (prev_gnt && s_rv) rv_ok++;
        check("dma4_grants", 0, 132'(grants), 132'd4);
        check("dma4_latency", 0, 132'(waits), 132'd1);
        check("dma4_rvalid", 0, 132'(rv_ok), 132'd4);
        idle(2);

        // Both requesting continuously: 16 core cycles, 8 DMA beats, repeat.
        bad = 0; grants = 0;
        core_req = 1'b1; dma_req = 1'b1; dma_we = 1'b0; core_we = 1'b0;
        for (int c = 0; c < 64; c++) begin
            step();
            exp_own = (c % 24) >= 16;
            if (s_gnt !== exp_own || s_stall !== exp_own) bad++;
            if (s_gnt) grants++;
        end
        check("starve_pattern", 0, 132'(bad), 132'd0);
        check("starve_grants", 0, 132'(grants), 132'd16);
        idle(2);

        // 20-beat write burst with the core idle never yields.
        bad = 0;
        dma_req = 1'b1; dma_we = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            dma_wdata = $urandom;
            step();
            if (s_gnt !== (c >= 1) || s_we !== (c >= 1) || s_stall) bad++;
        end
        check("long_burst", 0, 132'(bad), 132'd0);
        idle(2);

        // Core asks at beat 3: stalled through beat 8, then gets the port.
        bad = 0; stalls = 0;
        dma_req = 1'b1; dma_we = 1'b0; core_addr = 32'h0000_1234;
        for (int c = 0; c <= 9; c++) begin
            core_req = (c >= 3);
            step();
            if (s_gnt !== (c >= 1 && c <= 8) || s_stall !== (c >= 3 && c <= 8)) bad++;
            if (s_stall) stalls++;
        end
        check("yield_pattern", 0, 132'(bad), 132'd0);
        check("yield_stalls", 0, 132'(stalls), 132'd6);
        check("yield_owner", 0, 132'(s_addr), 132'(core_addr));
        idle(2);

        // Reset at read beat 5 of a burst.
        bad = 0;
        dma_req = 1'b1; dma_we = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            reset = (c == 5);
            step();
            if (s_gnt !== (c >= 1)) bad++;
        end
        reset = 1'b0; core_req = 1'b1; core_we = 1'b0;
        step();
        check("rst_burst_pre", 0, 132'(bad), 132'd0);
        check("rst_burst_post", 0, {129'd0, s_gnt, s_rv, s_stall}, 132'd0);
        idle(2);

        // Random traffic; DMA holds its request until granted.
        s_gnt = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            int unsigned mode;
            mode = (c / 200) % 3;
            if (!(dma_req && !s_gnt && !reset)) begin
                dma_req = $urandom_range(0, 3) != 0;
                dma_we = 1'($urandom); dma_addr = $urandom; dma_wdata = $urandom;
            end
            case (mode)
                0: core_req = 1'b1;
                1: core_req = $urandom_range(0, 3) != 0;
                default: core_req = $urandom_range(0, 3) == 0;
            endcase
            core_we = 1'($urandom); core_addr = $urandom; core_wdata = $urandom;
            reset = $urandom_range(0, 199) == 0;
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
